cordic_sincos_iter: RTL and testbench

Parametrised iterative CORDIC sine/cosine engine and successor to the fixed 8-bit, 12-step rotator.
- Accepts a full-circle binary angle through a valid/ready handshake.
- Folds the angle into the convergence range and runs ITER shift-add micro-rotations, one per clock.
- Returns rounded, saturated sine and cosine, held under output back-pressure.
- Sits between the angle/phase source and the downstream waveform/mixer logic.

---
 rtl/cordic_sincos_iter.sv | 201 ++++++++++++++++++++
 tb/tb_cordic_sincos_iter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_iter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_sincos_iter
// Description : Iterative CORDIC sine/cosine engine. It accepts a full-circle
//               binary angle, folds it into [-pi/2, pi/2), runs ITER
//               shift-add micro-rotations (one per clock), then returns
//               rounded, symmetrically saturated sine and cosine. The result
//               is held under output back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_sincos_iter #(
  parameter int DATA_W = 8,
  parameter int ITER   = 12,
  parameter int GUARD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] angle,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sine,
  output logic [DATA_W-1:0] cosine
);

  // Internal scale: 1.0 = 2^(INT_W-2) for x/y, pi = 2^(INT_W-1) for z.
  localparam int INT_W = DATA_W + GUARD + 2;
  localparam int CNT_W = 5;

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ROTATE = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  // Counter value reached after the last micro-rotation; the cycle spent at
  // this value performs the output rounding/saturation.
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ITER);

  // Round-to-nearest rescale of a high-precision constant by 2^-sh.
  function automatic longint rescale(input longint t, input int sh);
    longint r;
    if (sh > 0) r = (t + (64'sd1 <<< (sh - 1))) >>> sh;
    else        r = t <<< (-sh);
    return r;
  endfunction

  // atan(2^-i)/pi scaled so that pi = 2^23; rescaled to the datapath below.
  function automatic longint atan_q23(input int i);
    longint r;
    case (i)
      0:       r = 64'sd2097152;
      1:       r = 64'sd1238021;
      2:       r = 64'sd654136;
      3:       r = 64'sd332050;
      4:       r = 64'sd166669;
      5:       r = 64'sd83416;
      6:       r = 64'sd41718;
      7:       r = 64'sd20860;
      8:       r = 64'sd10430;
      9:       r = 64'sd5215;
      10:      r = 64'sd2608;
      11:      r = 64'sd1304;
      12:      r = 64'sd652;
      13:      r = 64'sd326;
      14:      r = 64'sd163;
      15:      r = 64'sd81;
      default: r = 64'sd0;
    endcase
    return r;
  endfunction

  // CORDIC gain compensation 0.6072529350 with 1.0 = 2^24.
  localparam longint c_X0_L = rescale(64'sd10188014, 26 - INT_W);
  localparam logic signed [INT_W-1:0] c_X0 = c_X0_L[INT_W-1:0];

  localparam longint c_HALF_L = 64'sd1 <<< GUARD;
  localparam longint c_MAX_L  = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
  localparam logic signed [INT_W:0] c_HALF = c_HALF_L[INT_W:0];
  localparam logic signed [INT_W:0] c_MAX  = c_MAX_L[INT_W:0];
  localparam logic signed [INT_W:0] c_MIN  = -c_MAX;

  logic signed [INT_W-1:0] w_atan_tab [16];

  for (genvar g = 0; g < 16; g++) begin : g_atan
    localparam longint c_A = rescale(atan_q23(g), 24 - INT_W);
    assign w_atan_tab[g] = c_A[INT_W-1:0];
  end

  logic [1:0]              r_state;
  logic [1:0]              w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [INT_W-1:0] r_x, r_y, r_z;
  logic                    r_fold;
  logic [DATA_W-1:0]       r_sine, r_cosine;

  // Angle folding: quadrants II/III are moved by pi and corrected at output.
  logic                    w_fold;
  logic [DATA_W-1:0]       w_afold;
  logic signed [INT_W-1:0] w_z0;

  assign w_fold  = angle[DATA_W-1] ^ angle[DATA_W-2];
  assign w_afold = {angle[DATA_W-1] ^ w_fold, angle[DATA_W-2:0]};
  assign w_z0    = {w_afold, {(INT_W-DATA_W){1'b0}}};

  // One micro-rotation step.
  logic                    w_dneg;
  logic signed [INT_W-1:0] w_xs, w_ys, w_at, w_xi, w_yi, w_zi;

  assign w_dneg = r_z[INT_W-1];
  assign w_xs   = r_x >>> r_cnt;
  assign w_ys   = r_y >>> r_cnt;
  assign w_at   = w_atan_tab[r_cnt[3:0]];
  assign w_xi   = w_dneg ? (r_x + w_ys) : (r_x - w_ys);
  assign w_yi   = w_dneg ? (r_y - w_xs) : (r_y + w_xs);
  assign w_zi   = w_dneg ? (r_z + w_at) : (r_z - w_at);

  // Output conversion: unfold, round half-up, drop to Q1.(DATA_W-1).
  logic signed [INT_W-1:0] w_xn, w_yn;
  logic signed [INT_W:0]   w_xr, w_yr;
  logic [DATA_W-1:0]       w_xq, w_yq;

  assign w_xn = r_fold ? -r_x : r_x;
  assign w_yn = r_fold ? -r_y : r_y;
  assign w_xr = ($signed({w_xn[INT_W-1], w_xn}) + c_HALF) >>> (GUARD + 1);
  assign w_yr = ($signed({w_yn[INT_W-1], w_yn}) + c_HALF) >>> (GUARD + 1);

  // Symmetric saturation so that +1.0 maps onto the largest positive code.
  always_comb begin
    w_xq = w_xr[DATA_W-1:0];
    w_yq = w_yr[DATA_W-1:0];
    if (w_xr > c_MAX)      w_xq = c_MAX[DATA_W-1:0];
    else if (w_xr < c_MIN) w_xq = c_MIN[DATA_W-1:0];
    if (w_yr > c_MAX)      w_yq = c_MAX[DATA_W-1:0];
    else if (w_yr < c_MIN) w_yq = c_MIN[DATA_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; requests are only taken in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:   if (in_valid && in_ready) w_next_state = c_ST_ROTATE;
      c_ST_ROTATE: if (r_cnt == c_LAST)      w_next_state = c_ST_DONE;
      c_ST_DONE:   if (out_ready)            w_next_state = c_ST_IDLE;
      default:                               w_next_state = c_ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (r_state == c_ST_IDLE) && !rst;
    out_valid = (r_state == c_ST_DONE);
  end

  // Datapath: load on accept, rotate, then register the rounded result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_fold   <= 1'b0;
      r_sine   <= '0;
      r_cosine <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (in_valid) begin
            r_x    <= c_X0;
            r_y    <= '0;
            r_z    <= w_z0;
            r_cnt  <= '0;
            r_fold <= w_fold;
          end
        end
        c_ST_ROTATE: begin
          if (r_cnt != c_LAST) begin
            r_x   <= w_xi;
            r_y   <= w_yi;
            r_z   <= w_zi;
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_sine   <= w_yq;
            r_cosine <= w_xq;
          end
        end
        default: ;
      endcase
    end
  end

  assign sine   = r_sine;
  assign cosine = r_cosine;

endmodule
`default_nettype wire

// File: tb/tb_cordic_sincos_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_sincos_iter
// Description : Self-checking bench for cordic_sincos_iter with a scoreboard
//               of requested angles and a real-valued sin/cos model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_sincos_iter;

  localparam int DATA_W = 8;
  localparam int ITER   = 12;
  localparam int GUARD  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] angle = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] sine;
  logic [DATA_W-1:0] cosine;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  cordic_sincos_iter #(.DATA_W(DATA_W), .ITER(ITER), .GUARD(GUARD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle     (angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sine      (sine),
    .cosine    (cosine)
  );

  always #5 clk = ~clk;

  // Ideal result in Q1.7, rounded and saturated to +/-127.
  function automatic int model(input int a, input bit want_sin);
    real ang, v;
    int  r;
    ang = a * 3.14159265358979 / 128.0;
    v   = want_sin ? $sin(ang) : $cos(ang);
    r   = int'(v * 128.0);
    if (r > 127)  r = 127;
    if (r < -127) r = -127;
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input int obs, input int exp,
                           input int tol);
    int d;
    d = (obs > exp) ? obs - exp : exp - obs;
    n_tests++;
    assert (d <= tol) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Present one angle and record it in the scoreboard when it is taken.
  task automatic send(input int a);
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check_eq($sformatf("in_ready_idle a=%0d", a), in_ready, 1);
    in_valid = 1'b1;
    angle    = a[DATA_W-1:0];
    exp_q.push_back(a);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq($sformatf("in_ready_busy a=%0d", a), in_ready, 0);
  endtask

  // Bounded wait for out_valid; cyc = negedges elapsed.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("out_valid_seen", out_valid, 1);
  endtask

  // Pop the oldest request and compare the presented result.
  task automatic check_out(input int tol_s, input int tol_c);
    int a;
    n_tests++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected>0");
    end
    if (exp_q.size() > 0) begin
      a = exp_q.pop_front();
      check_tol($sformatf("sine a=%0d", a), int'($signed(sine)), model(a, 1'b1), tol_s);
      check_tol($sformatf("cosine a=%0d", a), int'($signed(cosine)), model(a, 1'b0), tol_c);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("out_valid_drop", out_valid, 0);
    check_eq("in_ready_back", in_ready, 1);
  endtask

  task automatic run_one(input int a, input int tol_s, input int tol_c);
    int cyc;
    send(a);
    wait_out(cyc);
    check_eq($sformatf("latency a=%0d", a), cyc, ITER + 1);
    check_out(tol_s, tol_c);
    release_out();
  endtask

  initial begin
    int                cyc;
    logic [DATA_W-1:0] s0, c0;

    // Reset state.
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sine", sine, 0);
    check_eq("rst_cosine", cosine, 0);
    check_eq("rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("in_ready_after_rst", in_ready, 1);

    // Directed angles including the folded quadrants.
    run_one(0, 1, 0);
    run_one(64, 0, 1);
    run_one(32, 1, 1);
    run_one(-128, 1, 0);
    run_one(96, 1, 1);
    run_one(-32, 1, 1);

    // Back-pressure: result must hold while in_valid toggles.
    send(17);
    wait_out(cyc);
    check_out(1, 1);
    s0 = sine;
    c0 = cosine;
    for (int i = 0; i < 10; i++) begin
      in_valid = ~in_valid;
      angle    = 8'd5;
      @(negedge clk);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_sine", sine, s0);
      check_eq("bp_cosine", cosine, c0);
      check_eq("bp_in_ready", in_ready, 0);
    end
    // Completing handshake with a new request pending: taken one cycle later.
    in_valid  = 1'b1;
    angle     = 8'd40;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_release_out_valid", out_valid, 0);
    check_eq("bp_release_in_ready", in_ready, 1);
    exp_q.push_back(40);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_next_accepted", in_ready, 0);
    wait_out(cyc);
    check_eq("bp_next_latency", cyc, ITER + 1);
    check_out(1, 1);
    release_out();

    // Asynchronous reset in the middle of rotation.
    send(64);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_sine", sine, 0);
    check_eq("arst_cosine", cosine, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("arst_in_ready", in_ready, 1);
    run_one(64, 0, 1);

    // Full-circle sweep, back-to-back with the consumer always ready.
    out_ready = 1'b1;
    for (int a = -128; a < 128; a++) begin
      send(a);
      wait_out(cyc);
      check_out(2, 2);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("sweep_end_idle", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
